// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit add/subtract datapath among NUM_REQ
// valid/ready requesters, with one registered, ID-tagged response port that supports backpressure.
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  localparam int IDW    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_op,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic [IDW-1:0]           rsp_id,
  output logic [15:0]              ops_done
);

  localparam int             IDW1      = IDW + 1;
  localparam logic [IDW:0]   NUM_REQ_W = IDW1'(NUM_REQ);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e           state_q;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [15:0]      ops_done_q;

  logic             grant_valid;
  logic [IDW-1:0]   grant_idx;
  logic             can_accept, accept, rsp_fire;
  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   res_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
  end

  // Scan from ptr upward, wrapping at NUM_REQ; the first valid requester wins.
  always_comb begin
    logic [IDW:0] cand;
    // NOTE: every variable gets a default before the loop so this block never infers a latch.
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + IDW1'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!grant_valid && req_valid[cand[IDW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  assign can_accept = (state_q == EMPTY) || rsp_ready;
  // Gating with rst_n stops a requester from seeing an accept while the flops are held in reset.
  assign accept     = grant_valid && can_accept && rst_n;
  assign req_ready  = accept ? (NUM_REQ'(1) << grant_idx) : '0;
  assign rsp_fire   = (state_q == FULL) && rsp_ready;

  // Subtract is a + ~b + 1, so the carry out doubles as the unsigned no-borrow flag.
  always_comb begin
    op_a = a_arr[grant_idx];
    op_b = b_arr[grant_idx];
    if (req_op[grant_idx]) res_d = {1'b0, op_a} + {1'b0, ~op_b} + 1'b1;
    else                   res_d = {1'b0, op_a} + {1'b0, op_b};
    ptr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      rsp_id_q   <= '0;
      ptr_q      <= '0;
      ops_done_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
      case (state_q)
        EMPTY:   if (accept) state_q <= FULL;
        FULL:    if (rsp_ready && !accept) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
      if (accept) begin
        sum_q    <= res_d[WIDTH-1:0];
        carry_q  <= res_d[WIDTH];
        rsp_id_q <= grant_idx;
        ptr_q    <= ptr_d;
      end
      if (rsp_fire) ops_done_q <= ops_done_q + 16'd1;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign rsp_id    = rsp_id_q;
  assign ops_done  = ops_done_q;

endmodule
